// File: rtl/led_pwm_bank_if.sv
// Register strobe bus between the I2C register controller and the LED PWM bank.
// The controller is the master: it issues one-cycle write/read strobes and the bank returns registered read data.
interface led_pwm_bank_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic              reg_write;
    logic              reg_read;
    logic [7:0]        reg_rdata;

    modport master (
        output reg_addr,
        output reg_wdata,
        output reg_write,
        output reg_read,
        input  reg_rdata
    );

    modport slave (
        input  reg_addr,
        input  reg_wdata,
        input  reg_write,
        input  reg_read,
        output reg_rdata
    );
endinterface

// File: rtl/led_pwm_bank.sv
// N-channel LED PWM engine: register file, free-running PWM counter with period-aligned
// duty shadows, group dim/blink overlay and a SLEEP gate over all LED activity.
module led_pwm_bank #(
    parameter int NUM_CH   = 8,
    parameter int PWM_BITS = 8,
    parameter int ADDR_W   = 4
) (
    input  logic              clk_osc,
    input  logic              reset,
    led_pwm_bank_if.slave     bus,
    output logic              sleep,
    output logic [NUM_CH-1:0] leds
);
    localparam int NUM_LO    = (NUM_CH + 3) / 4;
    localparam int A_GRPPWM  = NUM_CH + 1;
    localparam int A_GRPFREQ = NUM_CH + 2;
    localparam int A_LEDOUT  = NUM_CH + 3;
    localparam int PW        = PWM_BITS + 8;
    localparam logic [PWM_BITS-1:0] PCNT_MAX = '1;

    logic [31:0]         addr;
    logic                mode_sleep;
    logic                mode_dmblnk;
    logic [7:0]          pwm_reg [NUM_CH];
    logic [7:0]          grppwm;
    logic [7:0]          grpfreq;
    logic [7:0]          ledout [NUM_LO];
    logic [7:0]          rd_val;
    logic [7:0]          rdata_q;

    logic [PWM_BITS-1:0] pcnt;
    logic [7:0]          bcnt;
    logic [7:0]          on_len_q;
    logic                dmblnk_seen;
    logic [PWM_BITS-1:0] duty_sh [NUM_CH];
    logic [PWM_BITS-1:0] dim_sh  [NUM_CH];

    logic                period_start;
    logic                period_end;
    logic [PWM_BITS-1:0] duty_new [NUM_CH];
    logic [PWM_BITS-1:0] dim_new  [NUM_CH];
    logic [PW-1:0]       dim_prod [NUM_CH];
    logic [15:0]         blink_prod;
    logic [7:0]          on_len_new;
    logic [7:0]          on_len_eff;
    logic                gate;
    logic [NUM_CH-1:0]   led_next;

    assign addr          = 32'(bus.reg_addr);
    assign sleep         = mode_sleep;
    assign bus.reg_rdata = rdata_q;

    always_ff @(posedge clk_osc) begin
        if (reset) begin
            mode_sleep  <= 1'b1;
            mode_dmblnk <= 1'b0;
            grppwm      <= 8'h00;
            grpfreq     <= 8'h00;
            for (int i = 0; i < NUM_CH; i++) pwm_reg[i] <= 8'h00;
            for (int k = 0; k < NUM_LO; k++) ledout[k] <= 8'h00;
        end else if (bus.reg_write) begin
            if (addr == 32'd0) begin
                mode_sleep  <= bus.reg_wdata[4];
                mode_dmblnk <= bus.reg_wdata[5];
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (addr == 32'(i + 1)) pwm_reg[i] <= bus.reg_wdata;
            end
            if (addr == 32'(A_GRPPWM))  grppwm  <= bus.reg_wdata;
            if (addr == 32'(A_GRPFREQ)) grpfreq <= bus.reg_wdata;
            for (int k = 0; k < NUM_LO; k++) begin
                if (addr == 32'(A_LEDOUT + k)) ledout[k] <= bus.reg_wdata;
            end
        end
    end

    always_comb begin
        rd_val = 8'h00;
        if (addr == 32'd0) rd_val = {2'b00, mode_dmblnk, mode_sleep, 4'h0};
        for (int i = 0; i < NUM_CH; i++) begin
            if (addr == 32'(i + 1)) rd_val = pwm_reg[i];
        end
        if (addr == 32'(A_GRPPWM))  rd_val = grppwm;
        if (addr == 32'(A_GRPFREQ)) rd_val = grpfreq;
        for (int k = 0; k < NUM_LO; k++) begin
            if (addr == 32'(A_LEDOUT + k)) rd_val = ledout[k];
        end
    end

    // Read data is captured from the pre-write register contents, so a same-cycle
    // write to the read address returns the old value.
    always_ff @(posedge clk_osc) begin
        if (reset) begin
            rdata_q <= 8'h00;
        end else if (bus.reg_read) begin
            rdata_q <= rd_val;
        end
    end

    assign period_start = (pcnt == '0);
    assign period_end   = (pcnt == PCNT_MAX);

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            duty_new[i] = pwm_reg[i][7 -: PWM_BITS];
            dim_prod[i] = PW'(duty_new[i]) * PW'({1'b0, grppwm} + 9'd1);
            dim_new[i]  = dim_prod[i][PW-1:8];
        end
        blink_prod = (16'(grpfreq) + 16'd1) * 16'(grppwm);
        on_len_new = blink_prod[15:8];
    end

    // At the latch point the freshly computed values are used directly, so the
    // first cycle of each period already reflects the new duty and blink length.
    always_comb begin
        led_next   = '0;
        on_len_eff = (period_start && bcnt == 8'd0) ? on_len_new : on_len_q;
        gate       = (bcnt < on_len_eff);
        for (int i = 0; i < NUM_CH; i++) begin
            case (ledout[i / 4][2 * (i % 4) +: 2])
                2'b00: led_next[i] = 1'b0;
                2'b01: led_next[i] = 1'b1;
                2'b10: led_next[i] = (pcnt < (period_start ? duty_new[i] : duty_sh[i]));
                default: begin
                    if (mode_dmblnk) begin
                        led_next[i] = (pcnt < (period_start ? duty_new[i] : duty_sh[i])) & gate;
                    end else begin
                        led_next[i] = (pcnt < (period_start ? dim_new[i] : dim_sh[i]));
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_osc) begin
        if (reset) begin
            pcnt        <= '0;
            bcnt        <= 8'd0;
            on_len_q    <= 8'd0;
            dmblnk_seen <= 1'b0;
            leds        <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_sh[i] <= '0;
                dim_sh[i]  <= '0;
            end
        end else if (mode_sleep) begin
            pcnt        <= '0;
            bcnt        <= 8'd0;
            dmblnk_seen <= mode_dmblnk;
            leds        <= '0;
        end else begin
            pcnt <= pcnt + PWM_BITS'(1);
            leds <= led_next;
            if (period_start) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    duty_sh[i] <= duty_new[i];
                    dim_sh[i]  <= dim_new[i];
                end
                if (bcnt == 8'd0) on_len_q <= on_len_new;
            end
            // A dim/blink change seen at the wrap restarts the blink sequence.
            if (period_end) begin
                if (mode_dmblnk != dmblnk_seen) begin
                    bcnt        <= 8'd0;
                    dmblnk_seen <= mode_dmblnk;
                end else if (bcnt >= grpfreq) begin
                    bcnt <= 8'd0;
                end else begin
                    bcnt <= bcnt + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_led_pwm_bank.sv
// Scoreboard bench for led_pwm_bank: a period-level reference model predicts LED, SLEEP
// and read data; a monitor process compares the DUT against the queued predictions.
module tb_led_pwm_bank;
    localparam int NCH    = 8;
    localparam int PB     = 8;
    localparam int AW     = 4;
    localparam int PER    = 1 << PB;
    localparam int NLO    = (NCH + 3) / 4;
    localparam int A_PWM1 = 1;
    localparam int A_GP   = NCH + 1;
    localparam int A_GF   = NCH + 2;
    localparam int A_LO0  = NCH + 3;

    typedef struct {
        logic [NCH-1:0] leds;
        logic           slp;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           sleep;
    logic [NCH-1:0] leds;

    int checks = 0;
    int errors = 0;

    exp_t exp_q[$];
    int   rd_q[$];

    // reference model state
    int m_sleep, m_dm, m_gp, m_gf;
    int m_pwm [NCH];
    int m_lo  [NLO];
    int m_t, m_bpos, m_onl, m_seen;
    int snap_d [NCH];
    int snap_g [NCH];

    led_pwm_bank_if #(.ADDR_W(AW)) bus ();

    led_pwm_bank #(.NUM_CH(NCH), .PWM_BITS(PB), .ADDR_W(AW)) dut (
        .clk_osc (clk),
        .reset   (rst),
        .bus     (bus),
        .sleep   (sleep),
        .leds    (leds)
    );

    always #5 clk = ~clk;

    function automatic int reg_val(input int a);
        if (a == 0) return (m_dm << 5) | (m_sleep << 4);
        if (a >= 1 && a <= NCH) return m_pwm[a-1];
        if (a == A_GP) return m_gp;
        if (a == A_GF) return m_gf;
        if (a >= A_LO0 && a < A_LO0 + NLO) return m_lo[a-A_LO0];
        return 0;
    endfunction

    task automatic model_reset();
        m_sleep = 1; m_dm = 0; m_gp = 0; m_gf = 0;
        m_t = 0; m_bpos = 0; m_onl = 0; m_seen = 0;
        for (int i = 0; i < NCH; i++) begin
            m_pwm[i] = 0; snap_d[i] = 0; snap_g[i] = 0;
        end
        for (int k = 0; k < NLO; k++) m_lo[k] = 0;
    endtask

    // Model of one clock edge: outputs follow from the registers before the edge,
    // then the write lands.
    always @(posedge clk) begin : model_p
        exp_t e;
        int a, code, on;
        a = int'(bus.reg_addr);
        e.leds = '0;
        if (rst) begin
            model_reset();
            e.slp = 1'b1;
        end else begin
            if (bus.reg_read) rd_q.push_back(reg_val(a));
            if (m_sleep != 0) begin
                m_t = 0; m_bpos = 0; m_seen = m_dm;
            end else begin
                if (m_t == 0) begin
                    for (int i = 0; i < NCH; i++) begin
                        snap_d[i] = m_pwm[i] >> (8 - PB);
                        snap_g[i] = (snap_d[i] * (m_gp + 1)) / 256;
                    end
                    if (m_bpos == 0) m_onl = ((m_gf + 1) * m_gp) / 256;
                end
                for (int i = 0; i < NCH; i++) begin
                    code = (m_lo[i/4] >> (2 * (i % 4))) & 3;
                    case (code)
                        0: on = 0;
                        1: on = 1;
                        2: on = (m_t < snap_d[i]) ? 1 : 0;
                        default: on = (m_dm != 0) ? ((m_t < snap_d[i] && m_bpos < m_onl) ? 1 : 0)
                                                  : ((m_t < snap_g[i]) ? 1 : 0);
                    endcase
                    e.leds[i] = (on != 0);
                end
                if (m_t == PER - 1) begin
                    if (m_dm != m_seen) begin
                        m_bpos = 0; m_seen = m_dm;
                    end else begin
                        m_bpos = (m_bpos >= m_gf) ? 0 : m_bpos + 1;
                    end
                end
                m_t = (m_t + 1) % PER;
            end
            if (bus.reg_write) begin
                if (a == 0) begin
                    m_sleep = (int'(bus.reg_wdata) >> 4) & 1;
                    m_dm    = (int'(bus.reg_wdata) >> 5) & 1;
                end else if (a >= 1 && a <= NCH) m_pwm[a-1] = int'(bus.reg_wdata);
                else if (a == A_GP) m_gp = int'(bus.reg_wdata);
                else if (a == A_GF) m_gf = int'(bus.reg_wdata);
                else if (a >= A_LO0 && a < A_LO0 + NLO) m_lo[a-A_LO0] = int'(bus.reg_wdata);
            end
            e.slp = (m_sleep != 0);
        end
        exp_q.push_back(e);
    end

    always @(posedge clk) begin : monitor_p
        logic rd_now;
        exp_t e;
        int   er;
        rd_now = bus.reg_read & ~rst;
        #1;
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (leds !== e.leds) begin
                errors++;
                $display("FAIL leds at %0t: got %h expected %h", $time, leds, e.leds);
            end
            checks++;
            if (sleep !== e.slp) begin
                errors++;
                $display("FAIL sleep at %0t: got %b expected %b", $time, sleep, e.slp);
            end
        end
        if (rd_now) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL rdata_queue_empty at %0t", $time);
            end else begin
                er = rd_q.pop_front();
                if (bus.reg_rdata !== 8'(er)) begin
                    errors++;
                    $display("FAIL rdata at %0t: got %h expected %h", $time, bus.reg_rdata, 8'(er));
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input int a, input int d);
        @(negedge clk);
        bus.reg_addr  = AW'(a);
        bus.reg_wdata = 8'(d);
        bus.reg_write = 1'b1;
        @(negedge clk);
        bus.reg_write = 1'b0;
    endtask

    task automatic rd(input int a, output int v);
        @(negedge clk);
        bus.reg_addr = AW'(a);
        bus.reg_read = 1'b1;
        @(negedge clk);
        bus.reg_read = 1'b0;
        v = int'(bus.reg_rdata);
    endtask

    task automatic rdwr(input int a, input int d);
        @(negedge clk);
        bus.reg_addr  = AW'(a);
        bus.reg_wdata = 8'(d);
        bus.reg_write = 1'b1;
        bus.reg_read  = 1'b1;
        @(negedge clk);
        bus.reg_write = 1'b0;
        bus.reg_read  = 1'b0;
    endtask

    task automatic wait_t(input int v);
        int n;
        n = 0;
        while (m_t != v && n < 3 * PER) begin
            @(negedge clk);
            n++;
        end
        if (m_t != v) begin
            checks++; errors++;
            $display("FAIL wait_timeout: pcnt %0d never reached %0d", m_t, v);
        end
    endtask

    // Counts high cycles of one channel over one PWM period starting at pcnt==0,
    // optionally issuing a register write at cycle wr_at of that period.
    task automatic count_period(input int ch, input bit skip, input int wr_at,
                                input int wa, input int wd, output int cnt, output int first);
        cnt = 0; first = -1;
        if (skip) @(negedge clk);
        wait_t(1);
        for (int i = 0; i < PER; i++) begin
            if (leds[ch]) begin
                cnt++;
                if (first < 0) first = i;
            end
            if (i == wr_at) begin
                bus.reg_addr  = AW'(wa);
                bus.reg_wdata = 8'(wd);
                bus.reg_write = 1'b1;
            end else begin
                bus.reg_write = 1'b0;
            end
            @(negedge clk);
        end
        bus.reg_write = 1'b0;
    endtask

    initial begin
        int v, c, f, op, d;
        bus.reg_addr  = '0;
        bus.reg_wdata = 8'h00;
        bus.reg_write = 1'b0;
        bus.reg_read  = 1'b0;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;

        chk("reset_leds", 32'(leds), 0);
        chk("reset_sleep", 32'(sleep), 1);
        chk("reset_rdata", 32'(bus.reg_rdata), 0);
        rd(0, v);  chk("read_mode_reset", v, 8'h10);
        rd(14, v); chk("read_unmapped", v, 0);
        wr(13, 8'h5A);
        rd(13, v); chk("write_unmapped_ignored", v, 0);

        wr(A_PWM1, 8'h40);
        wr(A_LO0, 8'h02);
        wr(0, 8'hCF);
        rd(0, v); chk("mode_reserved_bits", v, 0);
        count_period(0, 1'b1, -1, 0, 0, c, f);
        chk("duty40_count", c, 64);
        chk("duty40_align", f, 0);

        count_period(0, 1'b0, 100, A_PWM1, 8'hC0, c, f);
        chk("midperiod_old_duty", c, 64);
        count_period(0, 1'b0, -1, 0, 0, c, f);
        chk("next_period_new_duty", c, 192);

        wr(A_LO0, 8'h00);
        count_period(0, 1'b1, -1, 0, 0, c, f);
        chk("code00_off", c, 0);
        wr(A_LO0, 8'h01);
        count_period(0, 1'b1, -1, 0, 0, c, f);
        chk("code01_on", c, PER);

        wr(A_PWM1, 8'h80);
        wr(A_GP, 8'h7F);
        wr(A_LO0, 8'h03);
        count_period(0, 1'b1, -1, 0, 0, c, f);
        chk("dim_count", c, 64);

        wr(A_PWM1, 8'hFF);
        wr(A_GF, 3);
        wr(A_GP, 8'h80);
        wait_t(100);
        wr(0, 8'h20);
        count_period(0, 1'b1, -1, 0, 0, c, f); chk("blink_p0", c, 255);
        count_period(0, 1'b0, -1, 0, 0, c, f); chk("blink_p1", c, 255);
        count_period(0, 1'b0, -1, 0, 0, c, f); chk("blink_p2", c, 0);
        count_period(0, 1'b0, -1, 0, 0, c, f); chk("blink_p3", c, 0);

        wr(A_LO0, 8'h02);
        wait_t(50);
        wr(0, 8'h10);
        chk("pulse_before_sleep", 32'(leds[0]), 1);
        idle(1);
        chk("sleep_leds_off", 32'(leds), 0);
        chk("sleep_out", 32'(sleep), 1);
        wr(A_PWM1, 8'h30);
        rd(A_PWM1, v); chk("sleep_readback", v, 8'h30);
        idle(300);
        chk("sleep_still_dark", 32'(leds), 0);
        wr(0, 8'h00);
        count_period(0, 1'b1, -1, 0, 0, c, f);
        chk("wake_duty", c, 48);
        chk("wake_align", f, 0);

        wait_t(20);
        chk("pulse_before_reset", 32'(leds[0]), 1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("midrun_reset_leds", 32'(leds), 0);
        chk("midrun_reset_sleep", 32'(sleep), 1);
        chk("midrun_reset_rdata", 32'(bus.reg_rdata), 0);
        rd(A_PWM1, v); chk("midrun_reset_pwm1", v, 0);

        wr(0, 8'h00);
        for (int it = 0; it < 120; it++) begin
            idle($urandom_range(0, 400));
            op = $urandom_range(0, 39);
            if (op == 0) begin
                rst = 1'b1;
                idle($urandom_range(1, 3));
                rst = 1'b0;
                wr(0, 8'h00);
            end else if (op < 4) begin
                d = $urandom_range(0, 255) & 8'hEF;
                if ($urandom_range(0, 5) == 0) d = d | 8'h10;
                wr(0, d);
            end else if (op < 7) begin
                wr(A_GF, $urandom_range(0, 3));
            end else if (op < 24) begin
                wr($urandom_range(1, 15), $urandom_range(0, 255));
            end else if (op < 28) begin
                rdwr($urandom_range(0, 15), $urandom_range(0, 255));
            end else begin
                rd($urandom_range(0, 15), v);
            end
        end
        idle(5);
        chk("read_queue_drained", 32'(rd_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
